// File: rtl/ram_latency_ctrl.sv
// Word-addressed RAM with a programmable access latency. A request is held
// for LAT BUSY cycles and then served in a single ACCESS cycle.
module ram_latency_ctrl #(
  parameter int LAT   = 2,
  parameter int WORDS = 1024
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] memaddr,
  input  logic [31:0] memstore,
  input  logic        memREN,
  input  logic        memWEN,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate
);

  localparam int AW = $clog2(WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACC  = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          wr_q, wr_d;

  logic [31:0]   mem_q [WORDS];

  logic          req;
  logic          addr_ok;
  logic          bad;
  logic          valid;
  logic [AW-1:0] req_idx;

  // Aligned and below WORDS*4: the bits above the word index must be zero.
  assign req     = memREN | memWEN;
  assign addr_ok = (memaddr[1:0] == 2'b00) && (memaddr[31:AW+2] == '0);
  assign bad     = (memREN & memWEN) | (req & ~addr_ok);
  assign valid   = req & ~bad;
  assign req_idx = memaddr[AW+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    case (state_q)
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
        end else if (bad) begin
          state_d = S_ERR;
        end else if (req_idx != idx_q || memWEN != wr_q) begin
          idx_d = req_idx;
          wr_d  = memWEN;
          cnt_d = CNT_INIT;
        end else if (cnt_q == 4'd0) begin
          state_d = S_ACC;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      // IDLE, ACC and ERR share one rule: every valid request starts a fresh access.
      default: begin
        if (valid) begin
          state_d = S_WAIT;
          idx_d   = req_idx;
          wr_d    = memWEN;
          cnt_d   = CNT_INIT;
        end else if (bad) begin
          state_d = S_ERR;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
    end
  end

  // Storage is never reset; a reset during ACC suppresses the commit.
  always_ff @(posedge CLK) begin
    if (!nRST && state_q == S_ACC && wr_q) begin
      mem_q[idx_q] <= memstore;
    end
  end

  assign ramload  = (state_q == S_ACC && !wr_q) ? mem_q[idx_q] : 32'h0;
  assign ramstate = state_q;

endmodule

// File: tb/tb_ram_latency_ctrl.sv
// Bench for ram_latency_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model of the request protocol.
module tb_ram_latency_ctrl;

  localparam int LAT   = 2;
  localparam int WORDS = 1024;

  logic        CLK;
  logic        nRST;
  logic [31:0] memaddr;
  logic [31:0] memstore;
  logic        memREN;
  logic        memWEN;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  ram_latency_ctrl #(.LAT(LAT), .WORDS(WORDS)) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .memaddr (memaddr),
    .memstore(memstore),
    .memREN  (memREN),
    .memWEN  (memWEN),
    .ramload (ramload),
    .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Model: what ramstate shows, which word/op is being served, and how many
  // BUSY cycles have been shown since the access (re)started.
  logic [1:0]  m_state = 2'd0;
  logic [9:0]  m_idx   = '0;
  bit          m_wr    = 0;
  int          busy_n  = 0;
  logic [31:0] mmem   [WORDS];
  bit          mknown [WORDS];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit req, bad, valid;
    logic [9:0] ix;
    req   = memREN || memWEN;
    bad   = (memREN && memWEN) ||
            (req && (memaddr % 4 != 0 || memaddr >= 32'(WORDS * 4)));
    valid = req && !bad;
    ix    = 10'(memaddr / 4);
    if (nRST) begin
      m_state = 2'd0;
      m_idx   = '0;
      m_wr    = 0;
      busy_n  = 0;
    end else begin
      if (m_state == 2'd2 && m_wr) begin
        mmem[m_idx]   = memstore;
        mknown[m_idx] = 1;
      end
      if (m_state == 2'd1) begin
        if (!req) m_state = 2'd0;
        else if (bad) m_state = 2'd3;
        else if (ix != m_idx || memWEN != m_wr) begin
          m_idx  = ix;
          m_wr   = memWEN;
          busy_n = 1;
        end else if (busy_n == LAT) m_state = 2'd2;
        else busy_n++;
      end else begin
        if (valid) begin
          m_state = 2'd1;
          m_idx   = ix;
          m_wr    = memWEN;
          busy_n  = 1;
        end else if (bad) m_state = 2'd3;
        else m_state = 2'd0;
      end
    end
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
  end

  initial forever begin
    @(negedge CLK);
    if (chk_en) begin
      chk("ramstate", 32'(ramstate), 32'(m_state));
      if (m_state == 2'd2 && !m_wr) begin
        if (mknown[m_idx]) chk("ramload_access", ramload, mmem[m_idx]);
      end else begin
        chk("ramload_idle", ramload, 32'h0);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drop();
    memREN = 1'b0;
    memWEN = 1'b0;
  endtask

  task automatic do_access(input string nm, input bit wr, input logic [31:0] a,
                           input logic [31:0] d, output logic [31:0] rd);
    int n;
    memaddr  = a;
    memstore = d;
    memREN   = !wr;
    memWEN   = wr;
    n = 0;
    tick();
    while (ramstate == 2'd1 && n < 40) begin
      n++;
      tick();
    end
    chk({nm, "_busy_cycles"}, 32'(n), 32'(LAT));
    chk({nm, "_access"}, 32'(ramstate), 32'd2);
    rd = ramload;
    drop();
    tick();
    chk({nm, "_free"}, 32'(ramstate), 32'd0);
  endtask

  task automatic pick_req();
    int r;
    logic [31:0] a;
    r = $urandom_range(0, 15);
    a = 32'($urandom_range(0, 15)) * 4 + ($urandom_range(0, 1) != 0 ? 32'h3C0 : 32'h0);
    drop();
    memaddr = a;
    case (r)
      0, 1: ;
      2: begin memREN = 1'b1; memWEN = 1'b1; end
      3: begin memREN = 1'b1; memaddr = a | 32'($urandom_range(1, 3)); end
      4: begin memWEN = 1'b1; memaddr = 32'h1000 + a; end
      default: begin
        memWEN = ($urandom_range(0, 1) != 0);
        memREN = !memWEN;
      end
    endcase
  endtask

  initial begin
    logic [31:0] rd;
    nRST = 1'b1;
    memaddr = '0;
    memstore = '0;
    drop();
    tick();
    tick();
    nRST = 1'b0;
    chk("reset_state", 32'(ramstate), 32'd0);
    chk("reset_load", ramload, 32'h0);
    chk_en = 1;

    do_access("wr10", 1, 32'h10, 32'hDEADBEEF, rd);
    do_access("rd10", 0, 32'h10, 32'h0, rd);
    chk("rd10_data", rd, 32'hDEADBEEF);

    do_access("wr3fc", 1, 32'h3FC, 32'h12345678, rd);
    do_access("rd3fc", 0, 32'h3FC, 32'h0, rd);
    chk("rd3fc_data", rd, 32'h12345678);

    // Restart: address changes after the first BUSY cycle.
    do_access("wr20", 1, 32'h20, 32'h20202020, rd);
    do_access("wr24", 1, 32'h24, 32'h24242424, rd);
    memaddr = 32'h20;
    memREN  = 1'b1;
    tick();
    chk("rst_busy0", 32'(ramstate), 32'd1);
    memaddr = 32'h24;
    tick();
    chk("rst_busy1", 32'(ramstate), 32'd1);
    tick();
    chk("rst_busy2", 32'(ramstate), 32'd1);
    tick();
    chk("rst_access", 32'(ramstate), 32'd2);
    chk("rst_data", ramload, 32'h24242424);
    drop();
    tick();

    // Abort a write during BUSY.
    do_access("wr40", 1, 32'h40, 32'h11111111, rd);
    memaddr  = 32'h40;
    memstore = 32'hAAAA5555;
    memWEN   = 1'b1;
    tick();
    chk("abort_busy", 32'(ramstate), 32'd1);
    drop();
    tick();
    chk("abort_free", 32'(ramstate), 32'd0);
    do_access("rd40", 0, 32'h40, 32'h0, rd);
    chk("abort_data", rd, 32'h11111111);

    // Error cases, each held then dropped.
    for (int k = 0; k < 3; k++) begin
      memaddr = (k == 0) ? 32'h10 : (k == 1) ? 32'h1002 : 32'h1000;
      memREN  = 1'b1;
      memWEN  = (k == 0);
      tick();
      chk("err_enter", 32'(ramstate), 32'd3);
      tick();
      chk("err_hold", 32'(ramstate), 32'd3);
      drop();
      tick();
      chk("err_free", 32'(ramstate), 32'd0);
    end
    memaddr = 32'h1000;
    memREN  = 1'b1;
    tick();
    chk("err_again", 32'(ramstate), 32'd3);
    do_access("err_to_rd", 0, 32'h10, 32'h0, rd);
    chk("err_to_rd_data", rd, 32'hDEADBEEF);

    // Reset during the ACC cycle of a write.
    do_access("wr80", 1, 32'h80, 32'h80808080, rd);
    memaddr  = 32'h80;
    memstore = 32'h0F0F0F0F;
    memWEN   = 1'b1;
    tick();
    tick();
    tick();
    chk("rstacc_access", 32'(ramstate), 32'd2);
    nRST = 1'b1;
    drop();
    tick();
    chk("rstacc_free", 32'(ramstate), 32'd0);
    nRST = 1'b0;
    do_access("rd80", 0, 32'h80, 32'h0, rd);
    chk("rstacc_data", rd, 32'h80808080);

    // Randomized traffic: requests held until ACCESS, with occasional changes and resets.
    for (int c = 0; c < 3000; c++) begin
      nRST = ($urandom_range(0, 299) == 0);
      if (ramstate == 2'd2 || $urandom_range(0, 15) == 0) pick_req();
      memstore = $urandom;
      tick();
    end
    drop();
    nRST = 1'b0;
    tick();
    tick();

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/ram_latency_ctrl.md
# ram_latency_ctrl

Word-addressed RAM with a programmable access latency, sitting directly downstream of the multicore top level on the CPU-to-RAM port. It consumes the arbitrated request stream (address, store data, read/write enables) from the coherence controller and produces load data plus a ram state code. The coherence controller uses that code to stall and sequence its cache fills and write-backs. Its timing is deterministic, so single-core and dual-core regressions see identical memory behaviour.

## Interface
- LAT, default 2: wait cycles spent in BUSY before ACCESS; legal range 1..15.
- WORDS, default 1024: number of 32-bit words stored; must be a power of two.
- CLK  in  1  system clock; all state changes on the rising edge.
- nRST  in  1  reset, synchronous, active-high; sampled on the rising edge of CLK.
- memaddr  in  32  byte address of the request; word index is memaddr[$clog2(WORDS)+1:2].
- memstore  in  32  write data; sampled in the ACCESS cycle.
- memREN  in  1  read request; level, held by the requester until it sees ACCESS.
- memWEN  in  1  write request; level, held by the requester until it sees ACCESS.
- ramload  out  32  read data; valid only while ramstate = ACCESS, otherwise 32'h0.
- ramstate  out  2  state code: FREE = 0, BUSY = 1, ACCESS = 2, ERROR = 3. Driven only from registered state.

## Operation
- Internal states are IDLE, WAIT, ACC and ERR. They drive ramstate FREE, BUSY, ACCESS and ERROR respectively.
- Registered request fields: latched address, latched op (read or write) and a 4-bit down-counter cnt.
- A request is valid when exactly one of memREN or memWEN is high, memaddr[1:0] = 0 and memaddr < WORDS*4.
- A request is bad when memREN and memWEN are both high, or when the address is misaligned or out of range.
- IDLE:
  - valid request: latch address and op, cnt <= LAT-1, go to WAIT.
  - bad request: go to ERR.
  - no request: stay in IDLE.
- WAIT, first matching rule wins:
  - Request dropped: go to IDLE; the access is aborted and nothing is written.
  - Request bad: go to ERR.
  - Address or op differs from the latched values: relatch, cnt <= LAT-1, stay in WAIT (restart).
  - cnt = 0: go to ACC.
  - Otherwise: cnt <= cnt-1.
- ACC:
  - ramload = mem[latched index] when the latched op is a read.
  - For a latched write, mem[latched index] <= memstore at the end of the cycle; ramload = 0.
  - Next state: valid request present → relatch and go to WAIT (a new access, even if identical); bad request → ERR; none → IDLE.
- ERR:
  - Stays in ERR while the bad request is held.
  - Request dropped → IDLE.
  - Valid request → latch it and go to WAIT.
- Storage contents are not cleared by reset and are undefined at power-up. Reads of never-written words are don't-care.

## Timing
- Reset values: state IDLE, ramstate = FREE, ramload = 32'h0, cnt = 0, latched address = 0, latched op = read.
- Reset mid-operation: any pending access is discarded. A write that has not yet reached ACC never commits. If reset is asserted during the ACC cycle, the write also does not commit.
- Latency: a valid request first sampled at edge E gives BUSY for cycles E+1 .. E+LAT and ACCESS in cycle E+LAT+1. That is LAT+1 cycles from first sampling to ACCESS.
- ACCESS lasts exactly one cycle per access. Back-to-back accesses to the same address are separated by LAT BUSY cycles.
- A restart in WAIT resets the full LAT count from the edge that saw the change.
- Writes become readable on the access following ACC; there is no write-to-read bypass within the same cycle.
- Changing memstore during WAIT has no effect; only the value present in the ACC cycle is written.

## Test plan
- Reset then read with LAT = 2: preload addr 0x10 = 0xDEADBEEF via a write, then assert memREN at 0x10. Required: BUSY, BUSY, then ACCESS with ramload = 0xDEADBEEF; FREE once memREN drops.
- Write then read-back: write 0x12345678 to 0x3FC (last word when WORDS = 1024), then read 0x3FC. Required: ACCESS on cycle LAT+1 for each; readback = 0x12345678.
- Restart: during a read of 0x20, change memaddr to 0x24 after 1 BUSY cycle. Required: LAT further BUSY cycles, then ACCESS returning mem[0x24].
- Abort: drop memWEN during BUSY while writing 0xAAAA5555 to 0x40. Required: ramstate FREE next cycle; a later read of 0x40 returns the prior value.
- Errors: memREN & memWEN together, then memaddr 0x1002, then memaddr 0x1000. Required: ERROR each time, held until the request drops, then FREE. A valid request issued from ERR reaches ACCESS after LAT+1 cycles.
- Reset mid-write: assert nRST in the ACC cycle of a write of 0x0F0F0F0F to 0x80. Required: FREE next cycle; mem[0x80] keeps its old value.
